// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the CPU control unit, its datapath and the memory arbiter.
package cpu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOST = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_JZ  = 3'd5;
    localparam logic [2:0] OP_HLT = 3'd7;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single program/data memory between the CPU datapath and a host port,
// stalling the CPU only on a real conflict and bounding host wait with a starvation counter.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_en,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_wait_cnt;
    logic [DATA_W-1:0] r_host_rdata;
    logic              w_host;
    logic              w_cpu_acc;
    logic              w_starved;
    logic              w_grant;

    assign w_host    = r_state == S_HOST;
    assign w_cpu_acc = cpu_rd | cpu_wr;
    assign w_starved = r_wait_cnt == CW'(STARVE_LIMIT);
    assign w_grant   = host_req & (cpu_halt | ~w_cpu_acc | w_starved);

    // cpu_en depends only on registered state and CPU strobes, never on host_req
    assign mem_addr   = w_host ? host_addr : cpu_addr;
    assign mem_wdata  = w_host ? host_wdata : cpu_wdata;
    assign mem_wr     = w_host ? host_we : cpu_wr;
    assign mem_rd     = w_host ? ~host_we : cpu_rd;
    assign cpu_en     = w_host ? ~w_cpu_acc : 1'b1;
    assign cpu_rdata  = mem_rdata;
    assign host_ack   = r_state == S_ACK;
    assign host_rdata = r_host_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_host_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= w_grant ? S_HOST : S_IDLE;
                    r_wait_cnt <= (w_grant || !host_req) ? '0 :
                                  w_starved ? r_wait_cnt : r_wait_cnt + CW'(1);
                end
                S_HOST: begin
                    r_state <= S_ACK;
                    if (!host_we)
                        r_host_rdata <= mem_rdata;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a cycle-scheduled reference model.
module tb_mem_arbiter;

    localparam int LIM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_halt, cpu_rd, cpu_wr, cpu_en;
    logic [4:0] cpu_addr, host_addr, mem_addr;
    logic [7:0] cpu_wdata, cpu_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic       host_req, host_we, host_ack, mem_rd, mem_wr;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .cpu_halt(cpu_halt), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_en(cpu_en),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] env_mem [32];
    always @(posedge clk) if (mem_wr) env_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = env_mem[mem_addr];

    int n_chk = 0, n_err = 0;
    int cyc = 0;

    // Reference model: a granted host transaction is scheduled as (access cycle, ack cycle)
    logic [7:0] ref_mem [32];
    logic [7:0] exp_rdata = 8'h00;
    int acc_cyc = -10, ack_cyc = -10, waited = 0;
    int last_ack = -100, prev_ack = -100, req_start = 0, stalls = 0;
    logic exp_en_prev = 1'b1;

    logic       h_active = 1'b0, h_we = 1'b0;
    logic [4:0] h_addr = '0;
    logic [7:0] h_wdata = '0;
    logic       f_valid = 1'b0, f_we = 1'b0;
    logic [4:0] f_addr = '0;
    logic [7:0] f_wdata = '0;
    int k_host = 0, k_drop = 0, k_busy = 0, k_halt = 0;
    logic h_rd_only = 1'b0, abort_acc = 1'b0;
    logic fix_cpu = 1'b1, fix_halt = 1'b0, fix_rd = 1'b0, fix_wr = 1'b0;
    logic [4:0] fix_addr = '0;
    logic [7:0] fix_wdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic host_force(input logic we, input logic [4:0] a, input logic [7:0] d);
        f_valid = 1'b1; f_we = we; f_addr = a; f_wdata = d;
    endtask

    task automatic step();
        int r;
        logic in_acc, in_ack, cpu_acc, exp_en;
        @(negedge clk);
        rst = 1'b1;
        cyc++;
        if (cyc - 1 == ack_cyc) h_active = 1'b0;
        if (!h_active) begin
            if (f_valid) begin
                h_active = 1'b1; h_we = f_we; h_addr = f_addr; h_wdata = f_wdata;
                f_valid = 1'b0; req_start = cyc;
            end else if ($urandom_range(99) < k_host) begin
                h_active = 1'b1; h_we = h_rd_only ? 1'b0 : 1'($urandom_range(1));
                h_addr = 5'($urandom); h_wdata = 8'($urandom); req_start = cyc;
            end
        end else if (ack_cyc < cyc && acc_cyc < cyc && $urandom_range(99) < k_drop) begin
            h_active = 1'b0;
        end
        host_req = h_active; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
        if (exp_en_prev) begin
            if (fix_cpu) begin
                cpu_halt = fix_halt; cpu_rd = fix_rd; cpu_wr = fix_wr;
                cpu_addr = fix_addr; cpu_wdata = fix_wdata;
            end else begin
                r = $urandom_range(99);
                cpu_halt = $urandom_range(99) < k_halt;
                cpu_rd = r < k_busy / 2;
                cpu_wr = r >= k_busy / 2 && r < k_busy;
                cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
            end
        end
        #1;
        in_acc  = cyc == acc_cyc;
        in_ack  = cyc == ack_cyc;
        cpu_acc = cpu_rd | cpu_wr;
        exp_en  = in_acc ? !cpu_acc : 1'b1;
        check("cpu_en", 32'(cpu_en), 32'(exp_en));
        check("host_ack", 32'(host_ack), 32'(in_ack));
        check("mem_addr", 32'(mem_addr), 32'(in_acc ? h_addr : cpu_addr));
        check("mem_wr", 32'(mem_wr), 32'(in_acc ? h_we : cpu_wr));
        check("mem_rd", 32'(mem_rd), 32'(in_acc ? !h_we : cpu_rd));
        check("mem_wdata", 32'(mem_wdata), 32'(in_acc ? h_wdata : cpu_wdata));
        check("host_rdata", 32'(host_rdata), 32'(exp_rdata));
        if (!in_acc && cpu_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[cpu_addr]));
        if (in_ack) begin prev_ack = last_ack; last_ack = cyc; end
        if (!cpu_en) stalls++;
        if (abort_acc && in_acc) begin
            rst = 1'b0;
            #1;
            check("abort_mem_wr", 32'(mem_wr), 32'(cpu_wr));
            check("abort_ack", 32'(host_ack), 32'(0));
            check("abort_cpu_en", 32'(cpu_en), 32'(1));
            check("abort_rdata", 32'(host_rdata), 32'(0));
            if (cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
            acc_cyc = -10; ack_cyc = -10; waited = 0; exp_rdata = 8'h00;
            h_active = 1'b0; host_req = 1'b0; exp_en_prev = 1'b1; abort_acc = 1'b0;
            return;
        end
        if (in_acc) begin
            if (h_we) ref_mem[h_addr] = h_wdata;
            else exp_rdata = ref_mem[h_addr];
        end else if (cpu_wr) begin
            ref_mem[cpu_addr] = cpu_wdata;
        end
        if (cyc > ack_cyc) begin
            if (host_req && (cpu_halt || !cpu_acc || waited == LIM)) begin
                acc_cyc = cyc + 1; ack_cyc = cyc + 2; waited = 0;
            end else begin
                waited = host_req ? (waited < LIM ? waited + 1 : LIM) : 0;
            end
        end
        exp_en_prev = exp_en;
    endtask

    task automatic run_until_ack(input int maxc);
        int n = 0;
        int a = last_ack;
        while (last_ack == a && n < maxc) begin
            step();
            n++;
        end
        check("ack_timeout", 32'(last_ack != a), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            env_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        cpu_halt = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h0C; cpu_wdata = 8'h5A;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #12;
        check("rst_cpu_en", 32'(cpu_en), 32'(1));
        check("rst_host_ack", 32'(host_ack), 32'(0));
        check("rst_host_rdata", 32'(host_rdata), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'h0C);
        check("rst_mem_rd", 32'(mem_rd), 32'(1));
        check("rst_mem_wdata", 32'(mem_wdata), 32'h5A);

        fix_halt = 1'b1;
        host_force(1'b1, 5'h1A, 8'hA5);
        run_until_ack(20);
        check("halt_wr_lat", 32'(last_ack - req_start), 32'(2));
        host_force(1'b0, 5'h1A, 8'h00);
        run_until_ack(20);
        check("halt_rd_lat", 32'(last_ack - req_start), 32'(2));
        check("halt_rd_data", 32'(host_rdata), 32'hA5);

        fix_halt = 1'b0;
        stalls = 0;
        host_force(1'b1, 5'h05, 8'h3C);
        run_until_ack(20);
        check("free_lat", 32'(last_ack - req_start), 32'(2));
        check("free_stalls", 32'(stalls), 32'(0));

        fix_rd = 1'b1; fix_addr = 5'h1A;
        stalls = 0;
        host_force(1'b0, 5'h05, 8'h00);
        run_until_ack(20);
        check("starve_lat", 32'(last_ack - req_start), 32'(LIM + 2));
        check("starve_stalls", 32'(stalls), 32'(1));
        check("starve_rdata", 32'(host_rdata), 32'h3C);

        fix_rd = 1'b0; fix_wr = 1'b1; fix_addr = 5'h03; fix_wdata = 8'h11;
        host_force(1'b1, 5'h03, 8'h22);
        run_until_ack(20);
        fix_wr = 1'b0;
        host_force(1'b0, 5'h03, 8'h00);
        run_until_ack(20);
        check("conflict_final", 32'(host_rdata), 32'h11);

        fix_halt = 1'b1;
        abort_acc = 1'b1;
        host_force(1'b1, 5'h10, 8'hEE);
        for (int i = 0; i < 10 && abort_acc; i++) step();
        check("abort_reached", 32'(abort_acc), 32'(0));
        repeat (4) step();

        h_rd_only = 1'b1; k_host = 100;
        host_force(1'b0, 5'h1A, 8'h00);
        run_until_ack(20);
        run_until_ack(20);
        check("b2b_spacing", 32'(last_ack - prev_ack), 32'(3));
        check("b2b_req_held", 32'(host_req), 32'(1));

        fix_cpu = 1'b0; h_rd_only = 1'b0;
        k_host = 30; k_drop = 5; k_busy = 60; k_halt = 10;
        repeat (600) step();
        k_busy = 95; k_halt = 0;
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
